// File: rtl/x6_fifo_event_merger_if.sv
// Handshake bundle between the six-channel FIFO read controller, the event
// merger and the downstream consumer of the merged word stream.
interface x6_fifo_event_merger_if #(
  parameter int W = 32
);
  logic [5:0]     pok;
  logic [6*W-1:0] din;
  logic [5:0]     eoe;
  logic [5:0]     ch_en;
  logic           hold;
  logic [5:0]     pop;
  logic [W-1:0]   dout;
  logic [2:0]     dout_ch;
  logic           dout_eoe;
  logic           dout_valid;
  logic           evt_done;
  logic [15:0]    evt_cnt;
  logic [5:0]     tmo_err;

  modport master (
    output pok, din, eoe, ch_en, hold,
    input  pop, dout, dout_ch, dout_eoe, dout_valid, evt_done, evt_cnt, tmo_err
  );

  modport slave (
    input  pok, din, eoe, ch_en, hold,
    output pop, dout, dout_ch, dout_eoe, dout_valid, evt_done, evt_cnt, tmo_err
  );
endinterface

// File: rtl/x6_fifo_event_merger.sv
// Merges six FIFO channels into one word stream in strict channel order,
// one event at a time, with per-channel idle timeout and event counting.
module x6_fifo_event_merger #(
  parameter int W   = 32,
  parameter int TMO = 1023
) (
  input logic                    clk,
  input logic                    init_b,
  x6_fifo_event_merger_if.slave  bus
);
  localparam bit          TMO_EN   = (TMO > 0);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_NEXT} state_e;

  state_e       state_q, state_d;
  logic [2:0]   ch_q, ch_d;
  logic [15:0]  timer_q, timer_d;
  logic [5:0]   pop_q, pop_d;
  logic [W-1:0] dout_q, dout_d;
  logic [2:0]   dout_ch_q, dout_ch_d;
  logic         dout_eoe_q, dout_eoe_d;
  logic         dout_valid_q, dout_valid_d;
  logic         evt_done_q, evt_done_d;
  logic [15:0]  evt_cnt_q, evt_cnt_d;
  logic [5:0]   tmo_err_q, tmo_err_d;

  logic         cur_pok, cur_eoe, capture;
  logic [W-1:0] cur_din;
  logic [5:0]   rest_en;

  function automatic logic [2:0] lowest(input logic [5:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Channels strictly above c; c=5 yields an empty mask.
  function automatic logic [5:0] above(input logic [2:0] c);
    return ~((6'd2 << c) - 6'd1);
  endfunction

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    timer_d      = timer_q;
    pop_d        = '0;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_eoe_d   = dout_eoe_q;
    dout_valid_d = dout_valid_q & bus.hold;
    evt_done_d   = 1'b0;
    evt_cnt_d    = evt_cnt_q;
    tmo_err_d    = tmo_err_q;

    cur_pok = bus.pok[ch_q];
    cur_eoe = bus.eoe[ch_q];
    cur_din = bus.din[32'(ch_q) * W +: W];
    capture = (state_q == S_READ) && cur_pok && (!dout_valid_q || !bus.hold);
    rest_en = bus.ch_en & above(ch_q);

    case (state_q)
      S_IDLE: begin
        if (bus.ch_en != 6'd0) begin
          state_d = S_READ;
          ch_d    = lowest(bus.ch_en);
          timer_d = '0;
        end
      end
      S_READ: begin
        if (capture) begin
          pop_d[ch_q]  = 1'b1;
          dout_d       = cur_din;
          dout_ch_d    = ch_q;
          dout_eoe_d   = cur_eoe;
          dout_valid_d = 1'b1;
          state_d      = cur_eoe ? S_NEXT : S_GAP;
        end else if (!cur_pok && TMO_EN) begin
          // A stall on hold with a word present is not idle time.
          if (timer_q == TMO_LAST) begin
            tmo_err_d[ch_q] = 1'b1;
            state_d         = S_NEXT;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        state_d = S_READ;
        timer_d = '0;
      end
      default: begin
        timer_d = '0;
        if (rest_en != 6'd0) begin
          state_d = S_READ;
          ch_d    = lowest(rest_en);
        end else begin
          evt_done_d = 1'b1;
          evt_cnt_d  = evt_cnt_q + 16'd1;
          if (bus.ch_en != 6'd0) begin
            state_d = S_READ;
            ch_d    = lowest(bus.ch_en);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_b) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      timer_q      <= '0;
      pop_q        <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_eoe_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      evt_done_q   <= 1'b0;
      evt_cnt_q    <= '0;
      tmo_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      timer_q      <= timer_d;
      pop_q        <= pop_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_eoe_q   <= dout_eoe_d;
      dout_valid_q <= dout_valid_d;
      evt_done_q   <= evt_done_d;
      evt_cnt_q    <= evt_cnt_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign bus.pop        = pop_q;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_eoe   = dout_eoe_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.evt_done   = evt_done_q;
  assign bus.evt_cnt    = evt_cnt_q;
  assign bus.tmo_err    = tmo_err_q;
endmodule

// File: tb/tb_x6_fifo_event_merger.sv
// Bench for x6_fifo_event_merger: per-channel FIFO queues feed the DUT and an
// expected word stream built from the channel-order rules scores its output.
module tb_x6_fifo_event_merger;
  localparam int W   = 32;
  localparam int TMO = 16;

  logic clk    = 1'b0;
  logic init_b = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  x6_fifo_event_merger_if #(.W(W)) bus ();
  x6_fifo_event_merger #(.W(W), .TMO(TMO)) dut (.clk(clk), .init_b(init_b), .bus(bus));

  always #5 clk = ~clk;

  logic [W:0]   fq [6][$];
  logic [W+3:0] exp_q [$];
  logic [5:0]   mask_cur, pend_pop, prev_pop;
  logic [15:0]  cnt_base;
  logic [W-1:0] prev_dout;
  logic [2:0]   prev_ch;
  logic         prev_valid, prev_hold, prev_eoe;
  bit           mon_en, cad_en, hold_done, resume_due, gap_arm, saw_ch2;
  int           cyc, evt_seen, hold_mode, hold_left, last_cap, t_ch2, gap_4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int c = 0; c < 6; c++) begin
      if (fq[c].size() > 0) begin
        bus.pok[c]         = 1'b1;
        bus.din[c*W +: W]  = fq[c][0][W-1:0];
        bus.eoe[c]         = fq[c][0][W];
      end else begin
        bus.pok[c]         = 1'b0;
        bus.din[c*W +: W]  = '0;
        bus.eoe[c]         = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [W+3:0] e;
    if (prev_valid && prev_hold) begin
      check("freeze_word", {bus.dout_valid, bus.dout_ch, bus.dout_eoe, bus.dout},
            {1'b1, prev_ch, prev_eoe, prev_dout});
      check("freeze_pop", bus.pop, 6'd0);
    end else if (bus.pop == 6'd0) begin
      check("valid_clear", bus.dout_valid, 1'b0);
    end
    if (resume_due) begin
      check("hold_resume", bus.pop != 6'd0, 1'b1);
      resume_due = 1'b0;
    end
    if (bus.pop != 6'd0) begin
      check("pop_onehot", $countones(bus.pop), 1);
      check("pop_enabled", bus.pop & ~mask_cur, 6'd0);
      check("pop_back2back", bus.pop & prev_pop, 6'd0);
      check("pop_vs_ch", bus.pop, 6'd1 << bus.dout_ch);
      check("cap_valid", bus.dout_valid, 1'b1);
      check("stream_extra", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_word", {bus.dout_ch, bus.dout_eoe, bus.dout}, e);
      end
      if (cad_en && last_cap >= 0) check("cadence", cyc - last_cap, 2);
      last_cap = cyc;
      if (bus.dout_ch == 3'd2) saw_ch2 = 1'b1;
      if (bus.dout_ch == 3'd2 && bus.dout_eoe) t_ch2 = cyc;
      if (gap_arm && bus.dout_ch == 3'd4) begin
        gap_4   = cyc - t_ch2;
        gap_arm = 1'b0;
      end
    end
    if (bus.evt_done) begin
      evt_seen++;
      check("evt_cnt_pulse", bus.evt_cnt, 16'(cnt_base + evt_seen));
    end
  endtask

  task automatic step();
    logic hold_was;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 6; c++)
      if (pend_pop[c] && fq[c].size() > 0) void'(fq[c].pop_front());
    drive_fifo();
    if (mon_en) monitor();
    pend_pop   = bus.pop;
    prev_pop   = bus.pop;
    prev_valid = bus.dout_valid;
    prev_dout  = bus.dout;
    prev_ch    = bus.dout_ch;
    prev_eoe   = bus.dout_eoe;
    hold_was   = bus.hold;
    case (hold_mode)
      0: bus.hold = 1'b0;
      1: bus.hold = ($urandom_range(0, 2) == 0);
      default: begin
        if (!hold_done && bus.dout_valid) begin
          hold_done = 1'b1;
          hold_left = 10;
        end
        bus.hold = (hold_left > 0);
        if (hold_left > 0) hold_left--;
      end
    endcase
    if (hold_mode == 2 && hold_was && !bus.hold) resume_due = 1'b1;
    prev_hold = bus.hold;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    init_b    = 1'b0;
    bus.ch_en = 6'd0;
    bus.hold  = 1'b0;
    hold_mode = 0;
    step();
    for (int c = 0; c < 6; c++) fq[c].delete();
    exp_q.delete();
    pend_pop = '0;
    drive_fifo();
    check("rst_pop", bus.pop, 6'd0);
    check("rst_dout", {bus.dout_valid, bus.dout_eoe, bus.dout_ch, bus.dout}, 0);
    check("rst_evt", {bus.evt_done, bus.evt_cnt}, 0);
    check("rst_tmo", bus.tmo_err, 6'd0);
    init_b     = 1'b1;
    cnt_base   = 16'd0;
    prev_valid = 1'b0;
    prev_hold  = 1'b0;
    prev_pop   = '0;
    mon_en     = 1'b1;
  endtask

  // Reference stream: per event, enabled channels in ascending order, each
  // channel's words up to and including its eoe word; skip_ch gets no words.
  task automatic load(input logic [5:0] mask, input int nev, input int nw, input int skip_ch);
    int n;
    logic [W-1:0] d;
    for (int e = 0; e < nev; e++)
      for (int c = 0; c < 6; c++) begin
        if (c == skip_ch) continue;
        n = (nw > 0) ? nw : $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          d = $urandom;
          fq[c].push_back({k == n - 1, d});
          if (mask[c]) exp_q.push_back({3'(c), k == n - 1, d});
        end
      end
    evt_seen  = 0;
    last_cap  = -1;
    hold_done = 1'b0;
    hold_left = 0;
    mask_cur  = mask;
    bus.ch_en = mask;
    drive_fifo();
  endtask

  task automatic run(input int nev);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || evt_seen < nev) && n < 3000) begin
      step();
      n++;
    end
    check("run_completes", n < 3000, 1'b1);
    check("evt_count", evt_seen, nev);
    check("evt_cnt_final", bus.evt_cnt, 16'(cnt_base + nev));
    cnt_base = 16'(cnt_base + nev);
  endtask

  initial begin
    bus.pok = '0; bus.din = '0; bus.eoe = '0; bus.ch_en = '0; bus.hold = 1'b0;
    pend_pop = '0; prev_pop = '0; mask_cur = '0; cnt_base = '0;
    prev_valid = 1'b0; prev_hold = 1'b0; prev_dout = '0; prev_ch = '0; prev_eoe = 1'b0;
    mon_en = 1'b0; cad_en = 1'b0; hold_done = 1'b0; resume_due = 1'b0;
    gap_arm = 1'b0; saw_ch2 = 1'b0;
    cyc = 0; evt_seen = 0; hold_mode = 0; hold_left = 0; last_cap = -1; t_ch2 = 0; gap_4 = 0;

    // Power-on reset
    step();
    do_reset();

    // All channels, two words each, back-to-back cadence of one word per 2 cycles
    load(6'h3F, 1, 2, -1);
    cad_en = 1'b1;
    run(1);
    cad_en = 1'b0;
    repeat (3) step();
    check("evt_done_once", evt_seen, 1);
    check("tmo_clean_a", bus.tmo_err, 6'd0);

    // Channels 0 and 2 only, three events, random stalls; channel 1 holds junk
    do_reset();
    load(6'h05, 3, 0, -1);
    hold_mode = 1;
    run(3);

    // Ten-cycle hold on the first output word
    do_reset();
    load(6'h3F, 1, 0, -1);
    hold_mode = 2;
    run(1);
    check("hold_happened", hold_done, 1'b1);

    // Random masks with random stalls
    for (int r = 0; r < 4; r++) begin
      do_reset();
      load(6'($urandom_range(1, 63)), 2, 0, -1);
      hold_mode = 1;
      run(2);
      check("tmo_clean_r", bus.tmo_err, 6'd0);
    end

    // Channel 3 starved: timeout after TMO idle cycles, stream continues at 4
    do_reset();
    load(6'h3F, 1, 1, 3);
    gap_arm = 1'b1;
    run(1);
    check("tmo_err_ch3", bus.tmo_err, 6'h08);
    check("tmo_gap_2to4", gap_4, 2 + TMO + 1);
    repeat (40) step();
    check("tmo_sticky", bus.tmo_err[3], 1'b1);

    // Reset in the middle of channel 2, then a clean event from channel 0
    do_reset();
    load(6'h3F, 1, 3, -1);
    saw_ch2 = 1'b0;
    for (int n = 0; n < 500 && !saw_ch2; n++) step();
    check("reached_ch2", saw_ch2, 1'b1);
    do_reset();
    load(6'h3F, 1, 0, -1);
    run(1);

    // Event counter wrap from a preset value
    do_reset();
    @(negedge clk);
    force dut.evt_cnt_q = 16'hFFFE;
    step();
    step();
    @(negedge clk);
    release dut.evt_cnt_q;
    step();
    check("cnt_preset", bus.evt_cnt, 16'hFFFE);
    cnt_base = 16'hFFFE;
    load(6'h01, 3, 0, -1);
    hold_mode = 1;
    run(3);
    check("cnt_wrapped", bus.evt_cnt, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
